// File: rtl/drcp_pkg.sv
// Shared fetch-side types for the DRCP core, plus the instruction router's
// region-table and order-tracking definitions.
package drcp_pkg;

   // Fetch request: req qualifies addr.
   typedef struct packed {
      logic        req;
      logic [31:0] addr;
   } inst_req_t;

   // Fetch response: ack qualifies error and data.
   typedef struct packed {
      logic        ack;
      logic        error;
      logic [31:0] data;
   } inst_ack_t;

   // One memory-map window: inclusive base and inclusive last address.
   typedef struct packed {
      logic [31:0] base;
      logic [31:0] limit;
   } region_cfg_t;

   // Order-FIFO ids: 0..7 are downstream regions, ERR marks a locally answered fetch.
   localparam int             INST_RT_ID_W   = 4;
   localparam logic [3:0]     INST_RT_ERR_ID = 4'hF;

   // True when addr falls inside the window (unsigned compare).
   function automatic logic region_hit(input region_cfg_t cfg, input logic [31:0] addr);
      return (addr >= cfg.base) && (addr <= cfg.limit);
   endfunction

endpackage

// File: rtl/drcp_inst_ord_fifo.sv
// In-order tracking FIFO for the instruction router. Each entry records which
// target owes the response and whether a flush has since killed the fetch.
module drcp_inst_ord_fifo
   import drcp_pkg::*;
#(
   parameter int MAX_OUTST = 4,
   parameter int CNT_W     = $clog2(MAX_OUTST) + 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    i_push,
   input  logic [INST_RT_ID_W-1:0] i_push_id,
   input  logic                    i_pop,
   input  logic                    i_flush_kill,
   output logic [INST_RT_ID_W-1:0] o_head_id,
   output logic                    o_head_killed,
   output logic [CNT_W-1:0]        o_count,
   output logic                    o_empty,
   output logic                    o_full
);

   localparam int PTR_W = $clog2(MAX_OUTST);

   logic [INST_RT_ID_W-1:0] r_id [MAX_OUTST];
   logic [MAX_OUTST-1:0]    r_killed;
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;

   // Storage, pointers and occupancy. A flush marks every slot killed; the slot
   // written in the same cycle is overwritten with killed=0 (last NBA wins), so a
   // fetch accepted during the flush survives.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < MAX_OUTST; i++) r_id[i] <= '0;
         r_killed <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_flush_kill) r_killed <= '1;
         if (i_push) begin
            r_id[r_wr_ptr]     <= i_push_id;
            r_killed[r_wr_ptr] <= 1'b0;
            r_wr_ptr           <= r_wr_ptr + 1'b1;
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Head view and status flags.
   always_comb begin
      o_head_id     = r_id[r_rd_ptr];
      o_head_killed = r_killed[r_rd_ptr];
      o_count       = r_count;
      o_empty       = (r_count == '0);
      o_full        = (r_count == CNT_W'(MAX_OUTST));
   end

endmodule

// File: rtl/drcp_inst_router.sv
// Instruction-fetch router: decodes the fetch address against a region table,
// forwards the request to one target, and returns responses in accept order.
// Unmapped or misaligned fetches are answered locally with an error.
//
// Handshake: a request transfers in any cycle where up_req_i.req && up_rdy_o;
// up_rdy_o never depends on up_req_i.req. Downstream the same holds for
// dn_req_o[k].req && dn_rdy_i[k]. Responses are single-cycle pulses with no
// back-pressure: every ack presented is consumed in that cycle.
module drcp_inst_router
   import drcp_pkg::*;
#(
   parameter int                      N_REGION    = 4,
   parameter int                      MAX_OUTST   = 4,
   parameter logic [N_REGION*32-1:0]  REGION_BASE = '0,
   parameter logic [N_REGION*32-1:0]  REGION_END  = '0
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  inst_req_t                          up_req_i,
   output logic                               up_rdy_o,
   output inst_ack_t                          up_ack_o,
   input  logic                               flush_i,
   output inst_req_t [N_REGION-1:0]           dn_req_o,
   input  logic      [N_REGION-1:0]           dn_rdy_i,
   input  inst_ack_t [N_REGION-1:0]           dn_ack_i,
   output logic      [$clog2(MAX_OUTST):0]    outst_o,
   output logic                               proto_err_o
);

   localparam int CNT_W = $clog2(MAX_OUTST) + 1;

   logic [INST_RT_ID_W-1:0] w_sel;
   logic                    w_sel_err;
   logic                    w_dn_rdy_sel;
   logic                    w_accept;
   logic [INST_RT_ID_W-1:0] w_head_id;
   logic                    w_head_killed;
   logic                    w_head_err;
   inst_ack_t               w_head_ack;
   logic                    w_pop;
   logic                    w_unexp;
   logic [CNT_W-1:0]        w_count;
   logic                    w_empty;
   logic                    w_full;
   logic                    r_proto_err;

   // Address decode: scan from the top so the lowest matching index wins.
   always_comb begin
      w_sel = INST_RT_ERR_ID;
      for (int k = N_REGION - 1; k >= 0; k--) begin
         if (region_hit(region_cfg_t'{base:  REGION_BASE[k*32 +: 32],
                                      limit: REGION_END[k*32 +: 32]}, up_req_i.addr))
            w_sel = INST_RT_ID_W'(k);
      end
      if (up_req_i.addr[1:0] != 2'b00) w_sel = INST_RT_ERR_ID;
      w_sel_err = (w_sel == INST_RT_ERR_ID);
   end

   // Request steering: only the selected target sees the fetch; a full tracker
   // blocks everything (a pop this cycle does not free a slot until next cycle).
   always_comb begin
      dn_req_o     = '0;
      w_dn_rdy_sel = 1'b0;
      for (int k = 0; k < N_REGION; k++) begin
         if (w_sel == INST_RT_ID_W'(k)) begin
            dn_req_o[k].req  = up_req_i.req && !w_full;
            dn_req_o[k].addr = up_req_i.addr;
            w_dn_rdy_sel     = dn_rdy_i[k];
         end
      end
      up_rdy_o = !w_full && (w_sel_err || w_dn_rdy_sel);
      w_accept = up_req_i.req && up_rdy_o;
   end

   // Response return: only the head's owner may complete; error tokens complete
   // as soon as they reach the head. Killed or flush-cycle completions are dropped.
   always_comb begin
      w_head_ack = '0;
      w_unexp    = 1'b0;
      for (int k = 0; k < N_REGION; k++) begin
         if (w_head_id == INST_RT_ID_W'(k)) w_head_ack = dn_ack_i[k];
         if (dn_ack_i[k].ack && (w_empty || (w_head_id != INST_RT_ID_W'(k))))
            w_unexp = 1'b1;
      end
      w_head_err = (w_head_id == INST_RT_ERR_ID);
      w_pop      = !w_empty && (w_head_err || w_head_ack.ack);
      up_ack_o   = '0;
      if (w_pop && !w_head_killed && !flush_i) begin
         up_ack_o.ack   = 1'b1;
         up_ack_o.error = w_head_err ? 1'b1  : w_head_ack.error;
         up_ack_o.data  = w_head_err ? 32'h0 : w_head_ack.data;
      end
   end

   // Sticky protocol-error flag for acks nobody is waiting on.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        r_proto_err <= 1'b0;
      else if (w_unexp) r_proto_err <= 1'b1;
   end

   drcp_inst_ord_fifo #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (CNT_W)
   ) u_ord_fifo (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .i_push        (w_accept),
      .i_push_id     (w_sel),
      .i_pop         (w_pop),
      .i_flush_kill  (flush_i),
      .o_head_id     (w_head_id),
      .o_head_killed (w_head_killed),
      .o_count       (w_count),
      .o_empty       (w_empty),
      .o_full        (w_full)
   );

   assign outst_o     = w_count;
   assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_drcp_inst_router.sv
// Directed bench for drcp_inst_router: region decode, in-order return,
// local errors, full back-pressure, flush and mid-flight reset.
module tb_drcp_inst_router;
  import drcp_pkg::*;

  localparam logic [127:0] BASE = {32'h000F0000, 32'h00098000, 32'h00090000, 32'h00010000};
  localparam logic [127:0] LAST = {32'h000FFFFF, 32'h000AFFFF, 32'h0009FFFF, 32'h0001FFFF};

  logic                  clk;
  logic                  rst;
  inst_req_t             up_req;
  logic                  up_rdy;
  inst_ack_t             up_ack;
  logic                  flush;
  inst_req_t [3:0]       dn_req;
  logic      [3:0]       dn_rdy;
  inst_ack_t [3:0]       dn_ack;
  logic      [2:0]       outst;
  logic                  proto_err;

  int n_vec = 0;
  int n_err = 0;

  drcp_inst_router #(
    .N_REGION    (4),
    .MAX_OUTST   (4),
    .REGION_BASE (BASE),
    .REGION_END  (LAST)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .up_req_i    (up_req),
    .up_rdy_o    (up_rdy),
    .up_ack_o    (up_ack),
    .flush_i     (flush),
    .dn_req_o    (dn_req),
    .dn_rdy_i    (dn_rdy),
    .dn_ack_i    (dn_ack),
    .outst_o     (outst),
    .proto_err_o (proto_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] dn_bits();
    return {dn_req[3].req, dn_req[2].req, dn_req[1].req, dn_req[0].req};
  endfunction

  initial begin
    rst    = 1'b1;
    up_req = '0;
    flush  = 1'b0;
    dn_rdy = 4'hF;
    dn_ack = '0;

    // reset state
    #2;
    check("rst_outst", outst, 0);
    check("rst_rdy", up_rdy, 1);
    check("rst_ack", up_ack, 0);
    check("rst_dn_req", dn_req, 0);
    check("rst_proto", proto_err, 0);
    cyc(); cyc();
    rst = 1'b0;
    #1;

    // single fetch to r0, ack three cycles later
    up_req = '{req: 1'b1, addr: 32'h00010004};
    #1;
    check("a_dn_bits", dn_bits(), 4'b0001);
    check("a_dn_addr", dn_req[0].addr, 32'h00010004);
    check("a_rdy", up_rdy, 1);
    cyc();
    up_req = '0;
    #1;
    check("a_outst1", outst, 1);
    check("a_noack", up_ack, 0);
    cyc(); cyc(); cyc();
    dn_ack[0] = '{ack: 1'b1, error: 1'b0, data: 32'hdeadbeef};
    #1;
    check("a_ack", up_ack, {1'b1, 1'b0, 32'hdeadbeef});
    cyc();
    dn_ack[0] = '0;
    #1;
    check("a_outst0", outst, 0);

    // downstream back-pressure
    dn_rdy[0] = 1'b0;
    up_req = '{req: 1'b1, addr: 32'h00010000};
    #1;
    check("bp_rdy", up_rdy, 0);
    check("bp_dn_bits", dn_bits(), 4'b0001);
    cyc();
    check("bp_outst", outst, 0);
    dn_rdy = 4'hF;

    // overlap: r1 and r2 share 0x98000..0x9ffff, r1 wins
    up_req = '{req: 1'b1, addr: 32'h00098000};
    #1;
    check("ovl_r1", dn_bits(), 4'b0010);
    up_req = '{req: 1'b1, addr: 32'h000A0000};
    #1;
    check("ovl_r2", dn_bits(), 4'b0100);
    up_req = '0;
    cyc();

    // r1 acks before r0: ignored and flagged
    up_req = '{req: 1'b1, addr: 32'h00010000};
    cyc();
    up_req = '{req: 1'b1, addr: 32'h00090000};
    cyc();
    up_req = '0;
    #1;
    check("b_outst2", outst, 2);
    dn_ack[1] = '{ack: 1'b1, error: 1'b0, data: 32'h00001111};
    #1;
    check("b_early_ack", up_ack, 0);
    cyc();
    dn_ack[1] = '0;
    #1;
    check("b_proto", proto_err, 1);
    check("b_outst_hold", outst, 2);
    dn_ack[0] = '{ack: 1'b1, error: 1'b0, data: 32'h0000A0A0};
    #1;
    check("b_r0_ack", up_ack, {1'b1, 1'b0, 32'h0000A0A0});
    cyc();
    dn_ack[0] = '0;
    dn_ack[1] = '{ack: 1'b1, error: 1'b0, data: 32'h00001111};
    #1;
    check("b_r1_ack", up_ack, {1'b1, 1'b0, 32'h00001111});
    cyc();
    dn_ack[1] = '0;
    #1;
    check("b_outst0", outst, 0);

    // same pair, r1 answers only after r0
    up_req = '{req: 1'b1, addr: 32'h00010004};
    cyc();
    up_req = '{req: 1'b1, addr: 32'h00090004};
    cyc();
    up_req = '0;
    dn_ack[0] = '{ack: 1'b1, error: 1'b0, data: 32'h0000B0B0};
    #1;
    check("b2_r0_ack", up_ack, {1'b1, 1'b0, 32'h0000B0B0});
    cyc();
    dn_ack[0] = '0;
    dn_ack[1] = '{ack: 1'b1, error: 1'b1, data: 32'h0000C0C0};
    #1;
    check("b2_r1_ack", up_ack, {1'b1, 1'b1, 32'h0000C0C0});
    cyc();
    dn_ack[1] = '0;
    #1;
    check("b2_outst0", outst, 0);

    // unmapped and misaligned fetches answered locally
    up_req = '{req: 1'b1, addr: 32'h00000004};
    #1;
    check("c_unmap_dn", dn_bits(), 4'b0000);
    check("c_unmap_rdy", up_rdy, 1);
    cyc();
    up_req = '0;
    #1;
    check("c_unmap_ack", up_ack, {1'b1, 1'b1, 32'h0});
    cyc();
    check("c_unmap_idle", up_ack, 0);
    check("c_unmap_outst", outst, 0);
    up_req = '{req: 1'b1, addr: 32'h00010002};
    #1;
    check("c_mis_dn", dn_bits(), 4'b0000);
    cyc();
    up_req = '0;
    #1;
    check("c_mis_ack", up_ack, {1'b1, 1'b1, 32'h0});
    cyc();
    check("c_mis_outst", outst, 0);

    // fill to MAX_OUTST with acks stalled
    for (int i = 0; i < 4; i++) begin
      up_req = '{req: 1'b1, addr: 32'h00010000 + 32'(4 * i)};
      cyc();
    end
    up_req = '{req: 1'b1, addr: 32'h00010010};
    #1;
    check("d_outst4", outst, 4);
    check("d_full_rdy", up_rdy, 0);
    check("d_full_dn", dn_bits(), 4'b0000);
    dn_ack[0] = '{ack: 1'b1, error: 1'b0, data: 32'h00000100};
    #1;
    check("d_ack0", up_ack, {1'b1, 1'b0, 32'h00000100});
    check("d_no_credit", up_rdy, 0);
    cyc();
    dn_ack[0] = '0;
    #1;
    check("d_rdy_back", up_rdy, 1);
    check("d_outst3", outst, 3);
    up_req = '0;
    for (int i = 1; i < 4; i++) begin
      dn_ack[0] = '{ack: 1'b1, error: 1'b0, data: 32'h00000100 + 32'(i)};
      #1;
      check("d_drain", up_ack, {1'b1, 1'b0, 32'h00000100 + 32'(i)});
      cyc();
    end
    dn_ack[0] = '0;
    #1;
    check("d_outst0", outst, 0);

    // flush with a new request in the same cycle
    up_req = '{req: 1'b1, addr: 32'h00010000};
    cyc();
    up_req = '{req: 1'b1, addr: 32'h00010004};
    cyc();
    up_req = '{req: 1'b1, addr: 32'h00090000};
    flush  = 1'b1;
    #1;
    check("e_flush_rdy", up_rdy, 1);
    cyc();
    flush  = 1'b0;
    up_req = '0;
    #1;
    check("e_outst3", outst, 3);
    dn_ack[0] = '{ack: 1'b1, error: 1'b0, data: 32'h00000055};
    #1;
    check("e_kill0", up_ack, 0);
    cyc();
    dn_ack[0] = '{ack: 1'b1, error: 1'b0, data: 32'h00000066};
    #1;
    check("e_kill1", up_ack, 0);
    cyc();
    dn_ack[0] = '0;
    dn_ack[1] = '{ack: 1'b1, error: 1'b0, data: 32'h00000077};
    #1;
    check("e_r1_ack", up_ack, {1'b1, 1'b0, 32'h00000077});
    cyc();
    dn_ack[1] = '0;
    #1;
    check("e_outst0", outst, 0);

    // head popped in the flush cycle is suppressed
    up_req = '{req: 1'b1, addr: 32'h00010008};
    cyc();
    up_req = '0;
    dn_ack[0] = '{ack: 1'b1, error: 1'b0, data: 32'h00000088};
    flush = 1'b1;
    #1;
    check("f_pop_flush", up_ack, 0);
    cyc();
    dn_ack[0] = '0;
    flush = 1'b0;
    #1;
    check("f_outst0", outst, 0);

    // reset with three in flight
    for (int i = 0; i < 3; i++) begin
      up_req = '{req: 1'b1, addr: 32'h00010000 + 32'(4 * i)};
      cyc();
    end
    up_req = '0;
    #1;
    check("g_outst3", outst, 3);
    rst = 1'b1;
    dn_ack[0] = '{ack: 1'b1, error: 1'b0, data: 32'h00000099};
    #1;
    check("g_rst_outst", outst, 0);
    check("g_rst_rdy", up_rdy, 1);
    check("g_rst_ack", up_ack.ack, 0);
    check("g_rst_proto", proto_err, 0);
    cyc();
    dn_ack[0] = '0;
    rst = 1'b0;
    #1;
    check("g_post_outst", outst, 0);

    // ack with nothing in flight
    dn_ack[2] = '{ack: 1'b1, error: 1'b0, data: 32'h000000AA};
    #1;
    check("h_empty_ack", up_ack, 0);
    cyc();
    dn_ack[2] = '0;
    #1;
    check("h_proto", proto_err, 1);
    check("h_outst", outst, 0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
